// File: rtl/screen_pkg.sv
// Shared constants, state type and helpers for the whack-a-mole screen sequencer.
package screen_pkg;

  // Screen encodings seen by the pixel mux
  localparam logic [1:0] SCR_START = 2'd0;
  localparam logic [1:0] SCR_PLAY  = 2'd1;
  localparam logic [1:0] SCR_OVER  = 2'd2;

  // PS/2 set-2 scan codes of interest
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_BREAK = 8'hF0;

  // Largest score the three-digit text generator can show
  localparam logic [9:0] SCORE_MAX = 10'd999;

  // Sequencer states share the screen encoding so screen_sel is a plain copy
  typedef enum logic [1:0] {
    ST_START = SCR_START,
    ST_PLAY  = SCR_PLAY,
    ST_OVER  = SCR_OVER
  } screen_state_t;

  // Saturating score increment
  function automatic logic [9:0] score_inc(input logic [9:0] v);
    return (v >= SCORE_MAX) ? SCORE_MAX : v + 10'd1;
  endfunction

endpackage

// File: rtl/ps2_space_detect.sv
// Filters the PS/2 byte stream down to a one-cycle spacebar make strobe.
// A break prefix (F0) swallows the byte that follows it, so key releases
// never look like presses. The strobe is combinational so a press that
// lands on the same cycle as a frame tick can still commit on that tick.
module ps2_space_detect
  import screen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_key_valid,
  input  logic [7:0] i_key_code,
  output logic       o_space_press
);

  logic r_brk;

  // Break flag: armed by F0, consumed (and cleared) by the next byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_brk <= 1'b0;
    end else if (i_key_valid) begin
      if (r_brk) begin
        r_brk <= 1'b0;
      end else if (i_key_code == KEY_BREAK) begin
        r_brk <= 1'b1;
      end
    end
  end

  assign o_space_press = i_key_valid && !r_brk && (i_key_code == KEY_SPACE);

endmodule

// File: rtl/screen_controller.sv
// Top-level screen sequencer: START -> PLAY -> OVER -> START.
// Screen changes commit only on frame_tick so the display never tears.
// Keeps the countdown (frame-based) and the saturating hit score.
module screen_controller
  import screen_pkg::*;
#(
  parameter int GAME_SECONDS   = 30,
  parameter int FRAMES_PER_SEC = 60,
  parameter int OVER_HOLD_SEC  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       frame_tick,
  input  logic       hit,
  output logic [1:0] screen_sel,
  output logic       game_active,
  output logic [5:0] time_left,
  output logic [9:0] score,
  output logic       game_start_pulse,
  output logic       game_over_pulse
);

  // Worst case hold is 63 s * 255 frames = 16065 ticks, fits in 14 bits
  localparam int          LP_HOLD_FRAMES = OVER_HOLD_SEC * FRAMES_PER_SEC;
  localparam logic [5:0]  LP_TIME_INIT   = 6'(GAME_SECONDS);
  localparam logic [7:0]  LP_FRAME_LAST  = 8'(FRAMES_PER_SEC - 1);
  localparam logic [13:0] LP_HOLD_LAST   = 14'(LP_HOLD_FRAMES - 1);

  screen_state_t r_state;
  logic [1:0]    r_screen_sel;
  logic          r_game_active;
  logic [5:0]    r_time_left;
  logic [9:0]    r_score;
  logic          r_start_pulse;
  logic          r_over_pulse;
  logic [7:0]    r_frame_cnt;
  logic [13:0]   r_hold_cnt;
  logic          r_pend;

  logic w_space;
  logic w_req;
  logic w_sec_done;
  logic w_hold_done;

  ps2_space_detect u_space (
    .clk           (clk),
    .reset         (reset),
    .i_key_valid   (key_valid),
    .i_key_code    (key_code),
    .o_space_press (w_space)
  );

  // A press on this very cycle counts as a request alongside a stored one
  assign w_req       = r_pend | w_space;
  assign w_sec_done  = frame_tick && (r_frame_cnt == LP_FRAME_LAST);
  assign w_hold_done = frame_tick && (r_hold_cnt == LP_HOLD_LAST);

  // Sequencer: state, timers, score and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_START;
      r_screen_sel  <= SCR_START;
      r_game_active <= 1'b0;
      r_time_left   <= LP_TIME_INIT;
      r_score       <= 10'd0;
      r_start_pulse <= 1'b0;
      r_over_pulse  <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_hold_cnt    <= 14'd0;
      r_pend        <= 1'b0;
    end else begin
      r_start_pulse <= 1'b0;
      r_over_pulse  <= 1'b0;
      case (r_state)
        ST_START: begin
          if (frame_tick && w_req) begin
            r_state       <= ST_PLAY;
            r_screen_sel  <= SCR_PLAY;
            r_game_active <= 1'b1;
            r_score       <= 10'd0;
            r_time_left   <= LP_TIME_INIT;
            r_frame_cnt   <= 8'd0;
            r_pend        <= 1'b0;
            r_start_pulse <= 1'b1;
          end else if (w_space) begin
            r_pend <= 1'b1;
          end
        end

        ST_PLAY: begin
          // Presses during a game are dropped, not queued for later
          r_pend <= 1'b0;
          if (hit) begin
            r_score <= score_inc(r_score);
          end
          if (frame_tick) begin
            if (w_sec_done) begin
              r_frame_cnt <= 8'd0;
              r_time_left <= r_time_left - 6'd1;
              if (r_time_left == 6'd1) begin
                r_state       <= ST_OVER;
                r_screen_sel  <= SCR_OVER;
                r_game_active <= 1'b0;
                r_over_pulse  <= 1'b1;
                r_hold_cnt    <= 14'd0;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
            end
          end
        end

        ST_OVER: begin
          // Either a request or the hold timeout leaves; both together is one exit
          if (frame_tick) begin
            if (w_req || w_hold_done) begin
              r_state      <= ST_START;
              r_screen_sel <= SCR_START;
              r_pend       <= 1'b0;
              r_time_left  <= LP_TIME_INIT;
              r_hold_cnt   <= 14'd0;
            end else begin
              r_hold_cnt <= r_hold_cnt + 14'd1;
            end
          end else if (w_space) begin
            r_pend <= 1'b1;
          end
        end

        default: begin
          r_state       <= ST_START;
          r_screen_sel  <= SCR_START;
          r_game_active <= 1'b0;
          r_time_left   <= LP_TIME_INIT;
          r_pend        <= 1'b0;
        end
      endcase
    end
  end

  assign screen_sel       = r_screen_sel;
  assign game_active      = r_game_active;
  assign time_left        = r_time_left;
  assign score            = r_score;
  assign game_start_pulse = r_start_pulse;
  assign game_over_pulse  = r_over_pulse;

endmodule

// File: tb/tb_screen_controller.sv
// Randomized bench for screen_controller with an elapsed-frame reference model.
module tb_screen_controller;

  localparam int G = 3;
  localparam int F = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       frame_tick = 1'b0;
  logic       hit = 1'b0;
  logic [1:0] screen_sel;
  logic       game_active;
  logic [5:0] time_left;
  logic [9:0] score;
  logic       game_start_pulse;
  logic       game_over_pulse;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0/1/2, frames elapsed in PLAY and OVER, raw hit count
  int m_mode, m_pf, m_of, m_hits;
  bit m_brk, m_pend, m_sp, m_op;

  screen_controller #(
    .GAME_SECONDS   (G),
    .FRAMES_PER_SEC (F),
    .OVER_HOLD_SEC  (H)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .frame_tick       (frame_tick),
    .hit              (hit),
    .screen_sel       (screen_sel),
    .game_active      (game_active),
    .time_left        (time_left),
    .score            (score),
    .game_start_pulse (game_start_pulse),
    .game_over_pulse  (game_over_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_time();
    if (m_mode == 0) return G;
    if (m_mode == 1) return G - (m_pf / F);
    return 0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pf = 0; m_of = 0; m_hits = 0;
    m_brk = 0; m_pend = 0; m_sp = 0; m_op = 0;
  endtask

  task automatic model_step(input bit kv, input logic [7:0] kc, input bit ft, input bit h);
    bit space;
    space = 0;
    m_sp = 0;
    m_op = 0;
    if (kv) begin
      if (m_brk) m_brk = 0;
      else if (kc == 8'hF0) m_brk = 1;
      else if (kc == 8'h29) space = 1;
    end
    case (m_mode)
      0: begin
        if (ft && (m_pend || space)) begin
          m_mode = 1; m_pf = 0; m_hits = 0; m_pend = 0; m_sp = 1;
        end else if (space) m_pend = 1;
      end
      1: begin
        m_pend = 0;
        if (h) m_hits++;
        if (ft) begin
          m_pf++;
          if (m_pf == G * F) begin
            m_mode = 2; m_of = 0; m_op = 1;
          end
        end
      end
      default: begin
        if (ft) begin
          m_of++;
          if (m_pend || space || m_of == H * F) begin
            m_mode = 0; m_pend = 0;
          end
        end else if (space) m_pend = 1;
      end
    endcase
  endtask

  task automatic check_all(input string ph);
    check_val({ph, ".sel"},   int'(screen_sel), m_mode);
    check_val({ph, ".act"},   int'(game_active), (m_mode == 1) ? 1 : 0);
    check_val({ph, ".time"},  int'(time_left), exp_time());
    check_val({ph, ".score"}, int'(score), (m_hits > 999) ? 999 : m_hits);
    check_val({ph, ".spul"},  int'(game_start_pulse), int'(m_sp));
    check_val({ph, ".opul"},  int'(game_over_pulse), int'(m_op));
  endtask

  // One clock of stimulus, applied away from the edge and checked 1 ns after it
  task automatic step(input bit kv, input logic [7:0] kc, input bit ft, input bit h, input string ph);
    int prev;
    prev = m_mode;
    key_valid = kv; key_code = kc; frame_tick = ft; hit = h;
    model_step(kv, kc, ft, h);
    @(posedge clk);
    #1;
    check_all(ph);
    if (m_mode != prev)
      $display("[%0t] %s: screen %0d -> %0d time=%0d score=%0d", $time, ph, prev, m_mode, time_left, score);
    @(negedge clk);
    key_valid = 0; frame_tick = 0; hit = 0;
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, ph);
  endtask

  logic [7:0] codes [0:5];

  initial begin
    codes[0] = 8'h29; codes[1] = 8'hF0; codes[2] = 8'h29;
    codes[3] = 8'h1C; codes[4] = 8'hF0; codes[5] = 8'h29;

    // Reset state
    model_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1;
    @(negedge clk);

    // Space and tick on the same cycle start a game
    idle($urandom_range(0, 3), "pre");
    step(1, 8'h29, 1, 0, "go");
    check_val("go.sel_play", int'(screen_sel), 1);
    step(0, 8'h00, 0, 0, "go2");

    // First game: 12 ticks with stray presses and hits; final tick carries a hit
    for (int t = 0; t < G * F; t++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        step(($urandom % 3) == 0, 8'h29, 0, $urandom % 2, "play");
      step(($urandom % 2) == 0, 8'h29, 1, (t == G * F - 1) ? 1'b1 : 1'($urandom % 2), "play_tick");
    end
    check_val("over.sel", int'(screen_sel), 2);
    check_val("over.time", int'(time_left), 0);

    // OVER with hits but no keys: returns to START on the 8th tick
    for (int t = 0; t < H * F; t++) begin
      step(0, 8'h00, 0, 1, "over");
      step(0, 8'h00, 1, 1, "over_tick");
    end
    check_val("hold.sel", int'(screen_sel), 0);

    // A released space (F0 29) must not start a game
    step(1, 8'hF0, 0, 0, "brk");
    idle(2, "brk");
    step(1, 8'h29, 0, 0, "brk");
    step(0, 8'h00, 1, 0, "brk_tick");
    check_val("brk.sel", int'(screen_sel), 0);
    step(1, 8'h29, 0, 0, "press");
    idle(3, "press");
    step(0, 8'h00, 1, 0, "press_tick");
    check_val("press.sel", int'(screen_sel), 1);

    // Saturation game: hit every cycle, ticks sparse
    for (int t = 0; t < G * F; t++) begin
      for (int k = 0; k < 90; k++) step(0, 8'h00, 0, 1, "sat");
      step(0, 8'h00, 1, 1, "sat_tick");
    end
    check_val("sat.score", int'(score), 999);

    // Early exit from OVER with a space press
    step(1, 8'h29, 0, 0, "early");
    idle(2, "early");
    step(0, 8'h00, 1, 0, "early_tick");
    check_val("early.sel", int'(screen_sel), 0);
    check_val("early.score_kept", int'(score), 999);

    // Random mix of everything
    for (int i = 0; i < 4000; i++)
      step(($urandom % 6) == 0, codes[$urandom % 6], ($urandom % 3) == 0, $urandom % 2, "rand");

    // Drain back to START, clear any break prefix, then start a game
    for (int i = 0; i < 40 && m_mode != 0; i++) step(0, 8'h00, 1, 0, "drain");
    check_val("drain.mode", int'(screen_sel), 0);
    step(1, 8'h1C, 0, 0, "flush");
    step(1, 8'h1C, 0, 0, "flush");
    step(1, 8'h29, 1, 0, "go3");
    for (int t = 0; t < F; t++) step(0, 8'h00, 1, 1, "mid");
    check_val("mid.time", int'(time_left), 2);

    // Asynchronous reset mid-game takes effect without a clock edge
    #2;
    reset = 0;
    model_reset();
    #1;
    check_all("arst");
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    step(0, 8'h00, 1, 0, "post_arst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
